// File: rtl/oled_cmd_sequencer.sv
// oled_cmd_sequencer
// Brings the OLED panel out of reset, then streams the command ROM to the
// panel through i2c_master. Each I2C write is the control byte 0x00 followed
// by up to MAX_BURST command bytes. A NACKed write is repeated from the same
// ROM offset until the retry budget runs out. Completion and failure are
// reported on o_done / o_error.
module oled_cmd_sequencer #(
  parameter int         RST_CYCLES = 1_000_000,
  parameter int         SEQ_LEN    = 26,
  parameter int         MAX_BURST  = 16,
  parameter int         MAX_RETRY  = 2,
  parameter logic [7:0] DEV_ADDR   = 8'h3C,
  parameter int         AW         = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic [AW-1:0] o_rom_addr,
  input  logic [7:0]    i_rom_data,
  output logic          o_oled_rst_n,
  output logic [9:0]    o_slave_addr,
  output logic [7:0]    o_byte_cnt,
  output logic [3:0]    o_control_reg,
  output logic [3:0]    o_mode_reg,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_data_needed,
  input  logic          i_i2c_done,
  input  logic          i_i2c_nack,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error
);

  // base runs from 0 up to and including SEQ_LEN, so it needs one more code
  // than the ROM address.
  localparam int BW = $clog2(SEQ_LEN + 1);
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_LO,
    S_RST_HI,
    S_LOAD,
    S_START,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          busy_next;

  logic [CW-1:0] wait_cnt;
  logic [BW-1:0] base;
  logic [BW-1:0] base_plus;
  logic [RW-1:0] retry;
  logic [7:0]    sent;
  logic [7:0]    staging;
  logic [7:0]    chunk;
  logic          load_phase;
  logic          fetch_d1;
  logic          fetch_d2;
  int            remaining;

  logic          wait_last;
  logic          in_xfer;
  logic          nack_evt;
  logic          done_evt;
  logic          need_evt;
  logic          last_byte;
  logic          retry_ok;
  logic          seq_end;

  // The panel address and write mode never change.
  assign o_slave_addr = {2'b00, DEV_ADDR};
  assign o_mode_reg   = 4'b0000;

  // Chunk size for the current base, and the i2c_master events qualified by
  // state. A NACK wins over a simultaneous done; data requests are only
  // honoured in STREAM and only when no transaction end arrives with them.
  always_comb begin
    remaining = SEQ_LEN - int'(base);
    chunk     = (remaining < MAX_BURST) ? 8'(remaining) : 8'(MAX_BURST);
    base_plus = base + BW'(chunk);
    seq_end   = (int'(base) + int'(chunk)) >= SEQ_LEN;
    retry_ok  = int'(retry) < MAX_RETRY;
    wait_last = (wait_cnt == CW'(RST_CYCLES - 1));
    in_xfer   = (state == S_STREAM) || (state == S_WAIT_DONE);
    nack_evt  = in_xfer && i_i2c_nack;
    done_evt  = in_xfer && i_i2c_done && !i_i2c_nack;
    need_evt  = (state == S_STREAM) && i_tx_data_needed && !i_i2c_nack && !i_i2c_done;
    last_byte = need_evt && (sent == (chunk - 8'd1));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; busy is derived from where the FSM is heading so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_next = state;
    busy_next  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          state_next = S_RST_LO;
        end
      end
      S_RST_LO: begin
        if (wait_last) begin
          state_next = S_RST_HI;
        end
      end
      S_RST_HI: begin
        if (wait_last) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_phase) begin
          state_next = S_START;
        end
      end
      S_START: begin
        state_next = S_STREAM;
      end
      S_STREAM, S_WAIT_DONE: begin
        if (nack_evt) begin
          state_next = retry_ok ? S_LOAD : S_ERROR;
        end else if (done_evt) begin
          state_next = seq_end ? S_DONE : S_LOAD;
        end else if (last_byte) begin
          state_next = S_WAIT_DONE;
        end
      end
      S_DONE, S_ERROR: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    busy_next = (state_next == S_RST_LO) || (state_next == S_RST_HI) ||
                (state_next == S_LOAD)   || (state_next == S_START)  ||
                (state_next == S_STREAM) || (state_next == S_WAIT_DONE);
  end

  // Datapath: reset-pin timing, ROM addressing with a one-byte staging
  // register, transaction bookkeeping and the registered status outputs.
  // The ROM address is set on entry to LOAD so the second LOAD cycle sees
  // valid data; in STREAM the address advances on each data request and the
  // refetched byte lands in staging two cycles later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_oled_rst_n  <= 1'b1;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_control_reg <= 4'b0000;
      o_byte_cnt    <= 8'd0;
      o_tx_data     <= 8'd0;
      o_rom_addr    <= '0;
      wait_cnt      <= '0;
      base          <= '0;
      retry         <= '0;
      sent          <= 8'd0;
      staging       <= 8'd0;
      load_phase    <= 1'b0;
      fetch_d1      <= 1'b0;
      fetch_d2      <= 1'b0;
    end else begin
      o_oled_rst_n  <= (state_next != S_RST_LO);
      o_busy        <= busy_next;
      o_done        <= (state_next == S_DONE);
      o_control_reg <= (state_next == S_START) ? 4'b1000 : 4'b0000;

      if (((state == S_RST_LO) || (state == S_RST_HI)) && !wait_last) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end

      load_phase <= (state == S_LOAD) && !load_phase;
      fetch_d1   <= need_evt && !last_byte;
      fetch_d2   <= fetch_d1;

      if ((state == S_IDLE) && i_start) begin
        o_error <= 1'b0;
        base    <= '0;
        retry   <= '0;
      end

      if (state_next == S_ERROR) begin
        o_error <= 1'b1;
      end

      if ((state == S_RST_HI) && wait_last) begin
        o_rom_addr <= '0;
      end

      if (state == S_LOAD) begin
        o_byte_cnt <= chunk + 8'd1;
        o_tx_data  <= 8'h00;
        sent       <= 8'd0;
        if (load_phase) begin
          staging <= i_rom_data;
        end
      end else if (fetch_d2) begin
        staging <= i_rom_data;
      end

      if (need_evt) begin
        o_tx_data <= staging;
        sent      <= sent + 8'd1;
        if (!last_byte) begin
          o_rom_addr <= o_rom_addr + AW'(1);
        end
      end

      if (nack_evt) begin
        if (retry_ok) begin
          retry      <= retry + RW'(1);
          o_rom_addr <= AW'(base);
        end
      end else if (done_evt) begin
        base  <= base_plus;
        retry <= '0;
        if (!seq_end) begin
          o_rom_addr <= AW'(base_plus);
        end
      end
    end
  end

endmodule
